// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial A - B - BIN subtractor with start/busy/done handshake.
// One full subtractor (two half subtractors + borrow OR) reused LSB first.
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res;
  logic [IW-1:0]    idx;
  logic             br;

  logic hs1_d, hs1_b;
  logic hs2_d, hs2_b;
  logic br_nx;
  logic [WIDTH-1:0] res_nx;

  always_comb begin
    hs1_d  = a_sr[0] ^ b_sr[0];
    hs1_b  = ~a_sr[0] & b_sr[0];
    hs2_d  = hs1_d ^ br;
    hs2_b  = ~hs1_d & br;
    br_nx  = hs1_b | hs2_b;
    res_nx = {hs2_d, res[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      res        <= '0;
      idx        <= '0;
      br         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            br    <= bin;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          res  <= res_nx;
          br   <= br_nx;
          idx  <= idx + IW'(1);
          // last bit: publish result, results otherwise held
          if (idx == LAST) begin
            diff       <= res_nx;
            borrow_out <= br_nx;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
